// File: rtl/apb_2_axi_lite_if.sv
// apb_2_axi_lite_if: APB slave side and AXI4-Lite master side of the bridge in one bundle.
// Latency: none, this is only a signal container.
// Backpressure: PREADY stretches the APB access; each AXI channel uses VALID/READY.
// Modports: slave  = bridge view (APB request in, AXI request out, AXI response in).
//           master = environment view (drives APB, plays the AXI-Lite slave).
interface apb_2_axi_lite_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 4
);
  // APB
  logic [AXI_ADDR_WIDTH-1:0]   PADDR;
  logic [2:0]                  PPROT;
  logic                        PSEL;
  logic                        PENABLE;
  logic                        PWRITE;
  logic [AXI_DATA_WIDTH-1:0]   PWDATA;
  logic [AXI_DATA_WIDTH/8-1:0] PSTRB;
  logic                        PREADY;
  logic [AXI_DATA_WIDTH-1:0]   PRDATA;
  logic                        PSLVERR;
  // AXI4-Lite write address / data / response
  logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]                  M_AXI_AWPROT;
  logic                        M_AXI_AWVALID;
  logic                        M_AXI_AWREADY;
  logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                        M_AXI_WVALID;
  logic                        M_AXI_WREADY;
  logic [1:0]                  M_AXI_BRESP;
  logic                        M_AXI_BVALID;
  logic                        M_AXI_BREADY;
  // AXI4-Lite read address / data
  logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic [2:0]                  M_AXI_ARPROT;
  logic                        M_AXI_ARVALID;
  logic                        M_AXI_ARREADY;
  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]                  M_AXI_RRESP;
  logic                        M_AXI_RVALID;
  logic                        M_AXI_RREADY;

  modport slave (
    input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR,
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport master (
    output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR,
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/apb_2_axi_lite.sv
// apb_2_axi_lite: APB slave to AXI4-Lite master bridge, one transfer in flight at a time.
// Latency: 4 APB cycles (setup + 3 access) against a zero-wait AXI slave; each AXI wait adds one.
// Backpressure: PREADY is held low until the AXI response returns; AXI VALIDs hold until READY.
// Ports: M_AXI_ACLK (clock), M_AXI_ARESET (async active-high reset),
//        bus (apb_2_axi_lite_if.slave: APB request/response plus AXI-Lite master channels).
// All outputs come straight from flops; no input reaches an output combinationally.
module apb_2_axi_lite #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 4
) (
  input  logic             M_AXI_ACLK,
  input  logic             M_AXI_ARESET,
  apb_2_axi_lite_if.slave  bus
);

  localparam int DW = AXI_DATA_WIDTH;
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int SW = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Every registered output plus the two write-handshake flags.
  typedef struct packed {
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          rready;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic          aw_done;
    logic          w_done;
  } regs_t;

  state_t state_q, state_d;
  regs_t  r_q, r_d;

  logic setup;
  logic aw_hs, w_hs, ar_hs;
  logic aw_fin, w_fin;

  assign setup = bus.PSEL & ~bus.PENABLE;
  assign aw_hs = r_q.awvalid & bus.M_AXI_AWREADY;
  assign w_hs  = r_q.wvalid  & bus.M_AXI_WREADY;
  assign ar_hs = r_q.arvalid & bus.M_AXI_ARREADY;
  // A channel counts as finished if it completed earlier or is completing now,
  // so both handshakes landing in one cycle still advance in that cycle.
  assign aw_fin = r_q.aw_done | aw_hs;
  assign w_fin  = r_q.w_done  | w_hs;

  // Only RESP[1] distinguishes error (SLVERR/DECERR) from OKAY/EXOKAY.
  logic unused_resp_lsb;
  assign unused_resp_lsb = bus.M_AXI_BRESP[0] ^ bus.M_AXI_RRESP[0];

  // State register
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic. BREADY/RREADY are already high in the response states,
  // so the response VALID alone marks the handshake there.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (setup) state_d = bus.PWRITE ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_fin && w_fin) state_d = WR_RESP;
      WR_RESP: if (bus.M_AXI_BVALID) state_d = DONE;
      RD_REQ:  if (ar_hs) state_d = RD_RESP;
      RD_RESP: if (bus.M_AXI_RVALID) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next value of every output register.
  always_comb begin
    r_d = r_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          if (bus.PWRITE) begin
            r_d.awaddr  = bus.PADDR;
            r_d.awprot  = bus.PPROT;
            r_d.wdata   = bus.PWDATA;
            r_d.wstrb   = bus.PSTRB;
            r_d.awvalid = 1'b1;
            r_d.wvalid  = 1'b1;
            r_d.aw_done = 1'b0;
            r_d.w_done  = 1'b0;
          end else begin
            r_d.araddr  = bus.PADDR;
            r_d.arprot  = bus.PPROT;
            r_d.arvalid = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (aw_hs) begin
          r_d.awvalid = 1'b0;
          r_d.aw_done = 1'b1;
        end
        if (w_hs) begin
          r_d.wvalid = 1'b0;
          r_d.w_done = 1'b1;
        end
        if (aw_fin && w_fin) r_d.bready = 1'b1;
      end
      WR_RESP: begin
        if (bus.M_AXI_BVALID) begin
          r_d.bready  = 1'b0;
          r_d.pslverr = bus.M_AXI_BRESP[1];
          r_d.prdata  = '0;
          r_d.pready  = 1'b1;
        end
      end
      RD_REQ: begin
        if (ar_hs) begin
          r_d.arvalid = 1'b0;
          r_d.rready  = 1'b1;
        end
      end
      RD_RESP: begin
        if (bus.M_AXI_RVALID) begin
          r_d.rready  = 1'b0;
          r_d.prdata  = bus.M_AXI_RDATA;
          r_d.pslverr = bus.M_AXI_RRESP[1];
          r_d.pready  = 1'b1;
        end
      end
      DONE: begin
        // PREADY was raised on entry, so the pulse is exactly this one cycle.
        r_d.pready  = 1'b0;
        r_d.prdata  = '0;
        r_d.pslverr = 1'b0;
      end
      default: r_d = '0;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) r_q <= '0;
    else              r_q <= r_d;
  end

  assign bus.PREADY        = r_q.pready;
  assign bus.PRDATA        = r_q.prdata;
  assign bus.PSLVERR       = r_q.pslverr;
  assign bus.M_AXI_AWADDR  = r_q.awaddr;
  assign bus.M_AXI_AWPROT  = r_q.awprot;
  assign bus.M_AXI_AWVALID = r_q.awvalid;
  assign bus.M_AXI_WDATA   = r_q.wdata;
  assign bus.M_AXI_WSTRB   = r_q.wstrb;
  assign bus.M_AXI_WVALID  = r_q.wvalid;
  assign bus.M_AXI_BREADY  = r_q.bready;
  assign bus.M_AXI_ARADDR  = r_q.araddr;
  assign bus.M_AXI_ARPROT  = r_q.arprot;
  assign bus.M_AXI_ARVALID = r_q.arvalid;
  assign bus.M_AXI_RREADY  = r_q.rready;

endmodule

// File: tb/tb_apb_2_axi_lite.sv
// tb_apb_2_axi_lite: directed vector bench for the APB to AXI4-Lite bridge.
// Each vector is one APB transfer plus the wait states the AXI slave model inserts.
// Cycle 0 is the APB setup cycle; expected PREADY cycles are computed by hand.
module tb_apb_2_axi_lite;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_2_axi_lite_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) bus();

  apb_2_axi_lite #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .bus          (bus)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [2:0]    prot;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            a_wait;     // AWREADY (write) or ARREADY (read) delay
    int            w_wait;     // WREADY delay
    int            resp_wait;  // extra cycles before BVALID/RVALID
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
    logic          b2b;        // no idle cycle before this transfer
    logic          abort;      // reset once RREADY is seen
    int            exp_cyc;    // cycle of the PREADY pulse
    logic [DW-1:0] exp_prdata;
    logic          exp_err;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {bus.PREADY, bus.PRDATA, bus.PSLVERR,
            bus.M_AXI_AWADDR, bus.M_AXI_AWPROT, bus.M_AXI_AWVALID,
            bus.M_AXI_WDATA, bus.M_AXI_WSTRB, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
            bus.M_AXI_ARADDR, bus.M_AXI_ARPROT, bus.M_AXI_ARVALID, bus.M_AXI_RREADY};
  endfunction

  function automatic vec_t mk(input logic wr, input logic [AW-1:0] addr, input logic [2:0] prot,
                              input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                              input int a_wait, input int w_wait, input int resp_wait,
                              input logic [1:0] resp, input logic [DW-1:0] rdata,
                              input logic b2b, input logic abort, input int exp_cyc,
                              input logic [DW-1:0] exp_prdata, input logic exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.prot = prot; v.wdata = wdata; v.strb = strb;
    v.a_wait = a_wait; v.w_wait = w_wait; v.resp_wait = resp_wait;
    v.resp = resp; v.rdata = rdata; v.b2b = b2b; v.abort = abort;
    v.exp_cyc = exp_cyc; v.exp_prdata = exp_prdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic clear_axi_inputs();
    bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_BVALID = 1'b0;  bus.M_AXI_BRESP = 2'b00;
    bus.M_AXI_RVALID = 1'b0;  bus.M_AXI_RRESP = 2'b00; bus.M_AXI_RDATA = '0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("idle_pready_low", bus.PREADY, 0);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  // Drives one APB transfer and plays the AXI slave, all from the negedge.
  task automatic run_txn(input int idx, input vec_t v);
    int aw_n = 0, w_n = 0, ar_n = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    bit aw_prev = 0, w_prev = 0, ar_prev = 0;
    int resp_from = -1;
    bit resp_taken = 0;
    bit resp_vld;
    bit aborted = 0;
    int done_cyc = -1;

    @(negedge clk);
    check("prev_pready_cleared", bus.PREADY, 0);
    check("prev_prdata_cleared", bus.PRDATA, 0);
    check("prev_pslverr_cleared", bus.PSLVERR, 0);
    check("no_axi_activity_at_setup",
          {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY}, 0);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = v.wr;
    bus.PADDR = v.addr; bus.PPROT = v.prot; bus.PWDATA = v.wdata; bus.PSTRB = v.strb;
    clear_axi_inputs();

    for (int cyc = 1; cyc <= 40 && done_cyc < 0 && !aborted; cyc++) begin
      @(negedge clk);
      bus.PENABLE = 1'b1;
      if (aw_prev) check("awvalid_drop_after_hs", bus.M_AXI_AWVALID, 0);
      if (w_prev)  check("wvalid_drop_after_hs", bus.M_AXI_WVALID, 0);
      if (ar_prev) check("arvalid_drop_after_hs", bus.M_AXI_ARVALID, 0);
      aw_prev = 0; w_prev = 0; ar_prev = 0;
      check("single_valid_group",
            (bus.M_AXI_AWVALID | bus.M_AXI_WVALID | bus.M_AXI_BREADY) &
            (bus.M_AXI_ARVALID | bus.M_AXI_RREADY), 0);
      if (bus.M_AXI_BREADY) check("bready_after_both_hs", (aw_n == 1) && (w_n == 1), 1);

      if (bus.PREADY) begin
        done_cyc = cyc;
        check("prdata", bus.PRDATA, v.exp_prdata);
        check("pslverr", bus.PSLVERR, v.exp_err);
        clear_axi_inputs();
      end else if (v.abort && bus.M_AXI_RREADY) begin
        #2 rst = 1'b1;
        #1 check("reset_mid_rd_resp_outputs_zero", outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        clear_axi_inputs();
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        aborted = 1;
      end else begin
        bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && (aw_cnt >= v.a_wait);
        bus.M_AXI_WREADY  = bus.M_AXI_WVALID  && (w_cnt  >= v.w_wait);
        bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && (ar_cnt >= v.a_wait);
        if (bus.M_AXI_AWVALID) begin
          check("awaddr", bus.M_AXI_AWADDR, v.addr);
          check("awprot", bus.M_AXI_AWPROT, v.prot);
          aw_cnt++;
          if (bus.M_AXI_AWREADY) begin aw_n++; aw_prev = 1; end
        end
        if (bus.M_AXI_WVALID) begin
          check("wdata", bus.M_AXI_WDATA, v.wdata);
          check("wstrb", bus.M_AXI_WSTRB, v.strb);
          w_cnt++;
          if (bus.M_AXI_WREADY) begin w_n++; w_prev = 1; end
        end
        if (bus.M_AXI_ARVALID) begin
          check("araddr", bus.M_AXI_ARADDR, v.addr);
          check("arprot", bus.M_AXI_ARPROT, v.prot);
          ar_cnt++;
          if (bus.M_AXI_ARREADY) begin ar_n++; ar_prev = 1; end
        end
        if (resp_from < 0 && ((v.wr && aw_n == 1 && w_n == 1) || (!v.wr && ar_n == 1)))
          resp_from = cyc + 1 + v.resp_wait;
        resp_vld = (resp_from >= 0) && (cyc >= resp_from) && !resp_taken;
        bus.M_AXI_BVALID = v.wr && resp_vld;
        bus.M_AXI_BRESP  = (v.wr && resp_vld) ? v.resp : 2'b00;
        bus.M_AXI_RVALID = !v.wr && resp_vld;
        bus.M_AXI_RRESP  = (!v.wr && resp_vld) ? v.resp : 2'b00;
        bus.M_AXI_RDATA  = (!v.wr && resp_vld) ? v.rdata : '0;
        if ((bus.M_AXI_BVALID && bus.M_AXI_BREADY) || (bus.M_AXI_RVALID && bus.M_AXI_RREADY))
          resp_taken = 1;
      end
    end

    if (!aborted) begin
      if (done_cyc < 0) begin
        check($sformatf("v%0d_pready_timeout", idx), 0, 1);
      end else begin
        check($sformatf("v%0d_pready_cycle", idx), done_cyc, v.exp_cyc);
        check($sformatf("v%0d_aw_count", idx), aw_n, v.wr ? 1 : 0);
        check($sformatf("v%0d_w_count", idx), w_n, v.wr ? 1 : 0);
        check($sformatf("v%0d_ar_count", idx), ar_n, v.wr ? 0 : 1);
      end
    end
  endtask

  initial begin
    //            wr addr  prot  wdata          strb  aw/ar w   resp resp   rdata        b2b ab  cyc prdata       err
    vecs[0]  = mk(1, 4'h4, 3'd0, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0,        0, 0, 3, 32'h0,        0);
    vecs[1]  = mk(0, 4'h8, 3'd0, 32'h0,        4'h0, 0, 0, 2, 2'b00, 32'h12345678, 0, 0, 5, 32'h12345678, 0);
    vecs[2]  = mk(1, 4'hC, 3'd1, 32'hCAFEF00D, 4'h3, 3, 0, 0, 2'b00, 32'h0,        0, 0, 6, 32'h0,        0);
    vecs[3]  = mk(1, 4'h0, 3'd0, 32'h01020304, 4'h8, 0, 3, 0, 2'b01, 32'h0,        0, 0, 6, 32'h0,        0);
    vecs[4]  = mk(0, 4'h4, 3'd5, 32'h0,        4'h0, 0, 0, 0, 2'b11, 32'hA5A5A5A5, 0, 0, 3, 32'hA5A5A5A5, 1);
    vecs[5]  = mk(1, 4'h8, 3'd2, 32'h55AA55AA, 4'hF, 0, 0, 1, 2'b10, 32'h0,        0, 0, 4, 32'h0,        1);
    vecs[6]  = mk(0, 4'hC, 3'd0, 32'h0,        4'h0, 2, 0, 0, 2'b01, 32'h0BADF00D, 0, 0, 5, 32'h0BADF00D, 0);
    vecs[7]  = mk(1, 4'h4, 3'd0, 32'h11111111, 4'hF, 0, 0, 0, 2'b00, 32'h0,        1, 0, 3, 32'h0,        0);
    vecs[8]  = mk(0, 4'h0, 3'd7, 32'h0,        4'h0, 0, 0, 0, 2'b00, 32'h22222222, 1, 0, 3, 32'h22222222, 0);
    vecs[9]  = mk(1, 4'h8, 3'd0, 32'h33333333, 4'h5, 1, 1, 0, 2'b00, 32'h0,        1, 0, 4, 32'h0,        0);
    vecs[10] = mk(0, 4'h4, 3'd0, 32'h0,        4'h0, 0, 0, 30, 2'b00, 32'hFFFFFFFF, 0, 1, 0, 32'h0,       0);
    vecs[11] = mk(0, 4'h4, 3'd3, 32'h0,        4'h0, 0, 0, 0, 2'b00, 32'h87654321, 0, 0, 3, 32'h87654321, 0);

    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PPROT = '0; bus.PWDATA = '0; bus.PSTRB = '0;
    clear_axi_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs_zero", outs(), 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (!vecs[i].b2b) idle_cycle();
      run_txn(i, vecs[i]);
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
